// File: rtl/multi_debouncer_pkg.sv
// Shared defaults and parameter sanity check for the multi-channel hysteresis debouncer.
package multi_debouncer_pkg;

  localparam int unsigned DEB_CHANNELS    = 4;
  localparam int unsigned DEB_CNT_BITS    = 8;
  localparam int unsigned DEB_THRESH_HI   = 192;
  localparam int unsigned DEB_THRESH_LO   = 64;
  localparam int unsigned DEB_SYNC_STAGES = 2;

  function automatic bit deb_params_ok(input int unsigned cnt_bits, input int unsigned hi,
                                       input int unsigned lo, input int unsigned sync_stages,
                                       input int unsigned channels);
    longint cnt_max;
    cnt_max = (longint'(1) << cnt_bits) - longint'(1);
    return (lo < hi) && (longint'(hi) <= cnt_max) && (sync_stages >= 2) && (channels >= 1);
  endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// Pad-side inputs and debounced outputs of the multi-channel debouncer.
interface multi_debouncer_if
  import multi_debouncer_pkg::*;
#(
  parameter int unsigned CHANNELS = DEB_CHANNELS
) ();

  logic                sample_en;
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic                any_event;

  modport master (
    output sample_en,
    output din,
    input  level,
    input  rise_pulse,
    input  fall_pulse,
    input  any_event
  );

  modport slave (
    input  sample_en,
    input  din,
    output level,
    output rise_pulse,
    output fall_pulse,
    output any_event
  );

endinterface

// File: rtl/multi_debouncer_channel.sv
// Single-bit debouncer: synchroniser, saturating hysteresis counter, level and edge pulses.
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int unsigned CNT_BITS    = DEB_CNT_BITS,
  parameter int unsigned THRESH_HI   = DEB_THRESH_HI,
  parameter int unsigned THRESH_LO   = DEB_THRESH_LO,
  parameter int unsigned SYNC_STAGES = DEB_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sample_en,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_d,
  output logic o_fall_d
);

  localparam logic [CNT_BITS-1:0] CntMax   = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] ThreshHi = CNT_BITS'(THRESH_HI);
  localparam logic [CNT_BITS-1:0] ThreshLo = CNT_BITS'(THRESH_LO);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_BITS-1:0]    r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  logic                   w_sync_out;
  logic [CNT_BITS-1:0]    w_cnt_d;
  logic                   w_level_d;
  logic                   w_rise_d;
  logic                   w_fall_d;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Thresholds are compared against the post-update count so level moves on the same edge.
  always_comb begin
    w_cnt_d   = r_cnt;
    w_level_d = r_level;
    w_rise_d  = 1'b0;
    w_fall_d  = 1'b0;
    if (i_sample_en) begin
      if (w_sync_out && (r_cnt != CntMax)) begin
        w_cnt_d = r_cnt + CNT_BITS'(1);
      end else if (!w_sync_out && (r_cnt != '0)) begin
        w_cnt_d = r_cnt - CNT_BITS'(1);
      end
      if (!r_level && (w_cnt_d >= ThreshHi)) begin
        w_level_d = 1'b1;
        w_rise_d  = 1'b1;
      end else if (r_level && (w_cnt_d <= ThreshLo)) begin
        w_level_d = 1'b0;
        w_fall_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_cnt   <= w_cnt_d;
      r_level <= w_level_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
    end
  end

  assign o_level  = r_level;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_rise_d = w_rise_d;
  assign o_fall_d = w_fall_d;

endmodule

// File: rtl/multi_debouncer.sv
// N independent debounce channels plus a registered any-event flag aligned with the pulses.
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int unsigned CHANNELS    = DEB_CHANNELS,
  parameter int unsigned CNT_BITS    = DEB_CNT_BITS,
  parameter int unsigned THRESH_HI   = DEB_THRESH_HI,
  parameter int unsigned THRESH_LO   = DEB_THRESH_LO,
  parameter int unsigned SYNC_STAGES = DEB_SYNC_STAGES
) (
  input logic              clk,
  input logic              rst_n,
  multi_debouncer_if.slave deb_if
);

  if (!deb_params_ok(CNT_BITS, THRESH_HI, THRESH_LO, SYNC_STAGES, CHANNELS)) begin : g_bad_params
    $error("multi_debouncer: illegal parameter combination");
  end

  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_rise_d;
  logic [CHANNELS-1:0] w_fall_d;
  logic                r_any_event;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    debounce_channel #(
      .CNT_BITS    (CNT_BITS),
      .THRESH_HI   (THRESH_HI),
      .THRESH_LO   (THRESH_LO),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_sample_en (deb_if.sample_en),
      .i_din       (deb_if.din[g]),
      .o_level     (w_level[g]),
      .o_rise      (w_rise[g]),
      .o_fall      (w_fall[g]),
      .o_rise_d    (w_rise_d[g]),
      .o_fall_d    (w_fall_d[g])
    );
  end

  // Built from the pulse next-values so it lands in the same cycle as the pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_any_event <= 1'b0;
    end else begin
      r_any_event <= |(w_rise_d | w_fall_d);
    end
  end

  assign deb_if.level      = w_level;
  assign deb_if.rise_pulse = w_rise;
  assign deb_if.fall_pulse = w_fall;
  assign deb_if.any_event  = r_any_event;

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboarded bench for multi_debouncer with CNT_BITS=4, HI=12, LO=4, two sync stages.
module tb_multi_debouncer;

  localparam int unsigned NCh   = 4;
  localparam int          CMax  = 15;
  localparam int          THi   = 12;
  localparam int          TLo   = 4;

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exp_t       sb[$];
  int         m_cnt[NCh];
  logic [1:0] m_sync[NCh];
  logic [3:0] m_lvl;

  multi_debouncer_if #(.CHANNELS(NCh)) dif ();

  multi_debouncer #(
    .CHANNELS    (NCh),
    .CNT_BITS    (4),
    .THRESH_HI   (12),
    .THRESH_LO   (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .deb_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int c = 0; c < NCh; c++) begin
      m_cnt[c]  = 0;
      m_sync[c] = 2'b00;
    end
    m_lvl = 4'b0000;
  endfunction

  function automatic exp_t dut_out();
    exp_t o;
    o.lvl  = dif.level;
    o.rise = dif.rise_pulse;
    o.fall = dif.fall_pulse;
    o.any  = dif.any_event;
    return o;
  endfunction

  // Predict the outputs after the coming edge, queue them, then take that edge.
  task automatic step(input logic [3:0] d, input logic en);
    exp_t e;
    e = '0;
    for (int c = 0; c < NCh; c++) begin
      if (en) begin
        if (m_sync[c][1] && m_cnt[c] < CMax) m_cnt[c]++;
        else if (!m_sync[c][1] && m_cnt[c] > 0) m_cnt[c]--;
        if (!m_lvl[c] && m_cnt[c] >= THi) begin
          m_lvl[c]  = 1'b1;
          e.rise[c] = 1'b1;
        end else if (m_lvl[c] && m_cnt[c] <= TLo) begin
          m_lvl[c]  = 1'b0;
          e.fall[c] = 1'b1;
        end
      end
      m_sync[c] = {m_sync[c][0], d[c]};
    end
    e.lvl = m_lvl;
    e.any = |(e.rise | e.fall);
    sb.push_back(e);
    dif.din       = d;
    dif.sample_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t got;
    dif.din       = 4'b0000;
    dif.sample_en = 1'b1;
    rst_n = 1'b0;
    #3;
    got = dut_out();
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_during got=%h exp=0", got);
    end
    apply_reset();
    got = dut_out();
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_after got=%h exp=0", got);
    end
  endtask

  task automatic test_rise_saturate();
    exp_t e, got;
    for (int k = 1; k <= 24; k++) begin
      step(4'b0001, 1'b1);
      e = sb.pop_front();
      got = dut_out();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL rise_sb edge=%0d got=%h exp=%h", k, got, e);
      end
      total++;
      if (dif.rise_pulse[0] !== (k == 14) || dif.level[0] !== (k >= 14)) begin
        bad++;
        $display("FAIL rise_timing edge=%0d rise=%b level=%b exp_rise=%b exp_level=%b",
                 k, dif.rise_pulse[0], dif.level[0], (k == 14), (k >= 14));
      end
    end
  endtask

  task automatic test_fall_floor();
    exp_t e, got;
    for (int k = 1; k <= 20; k++) begin
      step(4'b0000, 1'b1);
      e = sb.pop_front();
      got = dut_out();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL fall_sb edge=%0d got=%h exp=%h", k, got, e);
      end
      total++;
      if (dif.fall_pulse[0] !== (k == 13) || dif.level[0] !== (k < 13)) begin
        bad++;
        $display("FAIL fall_timing edge=%0d fall=%b level=%b exp_fall=%b exp_level=%b",
                 k, dif.fall_pulse[0], dif.level[0], (k == 13), (k < 13));
      end
    end
    // A count that wrapped below zero would not need exactly 14 edges to rise again.
    for (int k = 1; k <= 16; k++) begin
      step(4'b0001, 1'b1);
      e = sb.pop_front();
      got = dut_out();
      total++;
      if (got !== e || dif.rise_pulse[0] !== (k == 14)) begin
        bad++;
        $display("FAIL floor_rerise edge=%0d got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_hysteresis();
    exp_t e, got;
    apply_reset();
    for (int k = 1; k <= 8; k++) begin
      step(4'b0010, 1'b1);
      e = sb.pop_front();
      got = dut_out();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL hyst_ramp edge=%0d got=%h exp=%h", k, got, e);
      end
    end
    for (int k = 0; k < 200; k++) begin
      step((k % 2 == 0) ? 4'b0000 : 4'b0010, 1'b1);
      e = sb.pop_front();
      got = dut_out();
      total++;
      if (got !== e || got.rise !== 4'b0000 || got.fall !== 4'b0000 || got.lvl[1] !== 1'b0) begin
        bad++;
        $display("FAIL hyst_toggle cycle=%0d got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_sample_enable();
    exp_t e, got;
    apply_reset();
    for (int j = 1; j <= 56; j++) begin
      step(4'b0100, (j % 4 == 0));
      e = sb.pop_front();
      got = dut_out();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL en_sb edge=%0d got=%h exp=%h", j, got, e);
      end
      total++;
      if (dif.rise_pulse[2] !== (j == 48) || dif.level[2] !== (j >= 48)) begin
        bad++;
        $display("FAIL en_timing edge=%0d rise=%b level=%b exp_rise=%b",
                 j, dif.rise_pulse[2], dif.level[2], (j == 48));
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e, got;
    logic [3:0] xr;
    apply_reset();
    for (int k = 1; k <= 16; k++) begin
      step(4'b1001, 1'b1);
      xr = (k == 14) ? 4'b1001 : 4'b0000;
      e = sb.pop_front();
      got = dut_out();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL simul_sb edge=%0d got=%h exp=%h", k, got, e);
      end
      total++;
      if (dif.rise_pulse !== xr || dif.any_event !== (k == 14)) begin
        bad++;
        $display("FAIL simul_pulse edge=%0d rise=%b any=%b exp_rise=%b exp_any=%b",
                 k, dif.rise_pulse, dif.any_event, xr, (k == 14));
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e, got;
    apply_reset();
    for (int k = 1; k <= 20; k++) begin
      step((k <= 14) ? 4'b0001 : 4'b0000, 1'b1);
      e = sb.pop_front();
      got = dut_out();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL arst_pre edge=%0d got=%h exp=%h", k, got, e);
      end
    end
    total++;
    if (dif.level[0] !== 1'b1) begin
      bad++;
      $display("FAIL arst_level_before got=%b exp=1", dif.level[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = dut_out();
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL arst_immediate got=%h exp=0", got);
    end
    model_reset();
    sb.delete();
    dif.din = 4'b0001;
    #3;
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(4'b0001, 1'b1);
      e = sb.pop_front();
      got = dut_out();
      total++;
      if (got !== e || dif.rise_pulse[0] !== (k == 14)) begin
        bad++;
        $display("FAIL arst_rerise edge=%0d got=%h exp=%h", k, got, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    dif.din       = 4'b0000;
    dif.sample_en = 1'b0;
    model_reset();
    test_reset();
    test_rise_saturate();
    test_fall_floor();
    test_hysteresis();
    test_sample_enable();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
